argmax_sequencer: RTL and testbench
===================================

ARGMAX_SEQUENCER -- requirements
Module: argmax_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 25, giving the unsigned score width.
REQ-002 The block SHALL have parameter N_CLASS, default 10, giving the scores per frame; the legal range is 2..16.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port score_in  input  DATA_W  unsigned class score, presented in class order 0..N_CLASS-1.
REQ-007 Port score_valid  input  1  score_in is valid.
REQ-008 Port score_ready  output  1  the block accepts a score this cycle.
REQ-009 Port result_valid  output  1  max_number and max_value hold a completed frame result.
REQ-010 Port result_ready  input  1  the consumer takes the result this cycle.
REQ-011 Port max_number  output  4  index of the winning class.
REQ-012 Port max_value  output  DATA_W  score of the winning class.
REQ-013 Port busy  output  1  high in any state other than COLLECT with zero scores held.

Function
REQ-014 The FSM SHALL have exactly three states: COLLECT, SCAN and DONE.
REQ-015 In COLLECT, score_ready SHALL be 1; a transfer occurs when score_valid and score_ready are both 1.
REQ-016 On each transfer, score_in SHALL be written to bank entry wr_cnt, and wr_cnt SHALL increment by 1.
REQ-017 A transfer with wr_cnt = N_CLASS-1 SHALL clear wr_cnt and move the FSM to SCAN on the next cycle.
REQ-018 In SCAN and DONE, score_ready SHALL be 0, and score_valid SHALL be ignored.
REQ-019 On SCAN entry, the running best SHALL be value 0 and index 0, and rd_cnt SHALL be 0.
REQ-020 In SCAN, exactly one entry SHALL be examined per cycle, for rd_cnt = 0..N_CLASS-1.
REQ-021 The running best SHALL be replaced only when the entry is strictly greater (unsigned) than the running best.
REQ-022 Ties SHALL therefore resolve to the lowest index, and an all-zero frame SHALL yield index 0 with value 0.
REQ-023 After the entry N_CLASS-1 is examined, the FSM SHALL move to DONE.
REQ-024 In DONE, result_valid SHALL be 1, and max_number and max_value SHALL be held stable.
REQ-025 Latency: if the last score is accepted on the edge ending cycle T, result_valid SHALL be 1 from cycle T+N_CLASS+1.
REQ-026 With result_valid and result_ready both 1, the FSM SHALL return to COLLECT on the next cycle, and result_valid SHALL drop.
REQ-027 The next frame may be accepted from that COLLECT cycle onward; there is no dead cycle beyond it.
REQ-028 The bank SHALL NOT be cleared between frames, and every entry SHALL be overwritten before it is scanned.
REQ-029 max_number and max_value SHALL update only on the SCAN-to-DONE transition and SHALL otherwise hold their last result.
REQ-030 Counter and index arithmetic SHALL be 4-bit unsigned, and counters SHALL never exceed N_CLASS-1.

Reset
REQ-031 When rst = 1 at a clock edge, the FSM SHALL enter COLLECT with wr_cnt = 0 and rd_cnt = 0, regardless of the current state.
REQ-032 Reset values SHALL be: score_ready 1, result_valid 0, max_number 0, max_value 0, busy 0.
REQ-033 A partially collected frame or an in-progress scan SHALL be discarded on reset, with no result produced.
REQ-034 Bank contents SHALL need no reset.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (COLLECT, SCAN, DONE) and the constant IDX_W = 4.
REQ-036 One sub-module, score_bank, SHALL be used: N_CLASS x DATA_W registers with one write port and one read port, with the read address driven by rd_cnt.
REQ-037 The FSM, the counters and the running-best compare SHALL reside in argmax_sequencer.

Verification
REQ-038 Frame 3,9,1,0,0,0,0,0,0,2, with result_ready held at 1: result_valid for 1 cycle, at T+11, with max_number 1 and max_value 9.
REQ-039 Frame of ten zeros: max_number 0, max_value 0.
REQ-040 Frame 5,7,7,0,0,0,0,0,7,0: max_number 1 (lowest index wins the tie).
REQ-041 Frame with score 2^25-1 at index 9 and all others 1: max_number 9, max_value 0x1FFFFFF.
REQ-042 result_ready held at 0 for 20 cycles: score_ready stays 0, the result is held stable, and a later handshake accepts the next frame.
REQ-043 rst asserted after 4 scores, then a full new frame 0,0,0,0,0,0,8,0,0,0: no result for the aborted frame, then max_number 6.
REQ-044 rst asserted mid-SCAN: result_valid stays 0, and score_ready = 1 on the next cycle.

Source files
------------

// File: rtl/argmax_sequencer_pkg.sv
// Shared definitions for the argmax sequencer.
//   IDX_W   : width of the class index and of every counter
//   state_t : sequencer FSM states
//             COLLECT = take one frame of scores
//             SCAN    = walk the bank
//             DONE    = hold the result until the consumer takes it
package argmax_sequencer_pkg;

    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCAN    = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/argmax_sequencer_if.sv
// Bus between the argmax sequencer and its producer/consumer.
//   score_in / score_valid / score_ready : score stream into the block
//   result_valid / result_ready          : frame result out of the block
//   max_number / max_value               : winning class index and its score
// Handshake rule for both channels: a beat transfers on a rising clock
// edge where valid and ready are both 1. The block drives score_ready and
// result_valid from its state only, so they never depend combinationally
// on the other side's valid/ready.
// The master modport is the producer/consumer side; slave is the block.
interface argmax_sequencer_if #(
    parameter int DATA_W = 25
);
    logic [DATA_W-1:0]                      score_in;
    logic                                   score_valid;
    logic                                   score_ready;
    logic                                   result_valid;
    logic                                   result_ready;
    logic [argmax_sequencer_pkg::IDX_W-1:0] max_number;
    logic [DATA_W-1:0]                      max_value;

    modport master (
        output score_in, score_valid, result_ready,
        input  score_ready, result_valid, max_number, max_value
    );

    modport slave (
        input  score_in, score_valid, result_ready,
        output score_ready, result_valid, max_number, max_value
    );
endinterface

// File: rtl/argmax_sequencer_score_bank.sv
// Score bank: N_CLASS x DATA_W register file, one write port and one
// asynchronous read port. Contents are not reset; every entry is written
// before it is read in a frame.
//   clk     : clock
//   we      : write enable
//   wr_addr : write entry
//   wr_data : write data
//   rd_addr : read entry
//   rd_data : read data (combinational from rd_addr)
module score_bank
    import argmax_sequencer_pkg::*;
#(
    parameter int DATA_W  = 25,
    parameter int N_CLASS = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    // Only the low address bits needed to reach N_CLASS entries are used;
    // the counters driving the addresses never exceed N_CLASS-1.
    localparam int AW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

    logic [DATA_W-1:0] mem [N_CLASS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr[AW-1:0]];

endmodule

// File: rtl/argmax_sequencer.sv
// Argmax sequencer: collects one frame of N_CLASS unsigned scores, scans
// them one per cycle and presents the index and value of the largest.
// Ties go to the lowest index; an all-zero frame yields index 0, value 0.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : score stream in, result out (slave side)
//   busy  : high unless idle in COLLECT with no scores held
//   state : current FSM state, for observation
module argmax_sequencer
    import argmax_sequencer_pkg::*;
#(
    parameter int DATA_W  = 25,
    parameter int N_CLASS = 10
) (
    input  logic                clk,
    input  logic                rst,
    argmax_sequencer_if.slave   bus,
    output logic                busy,
    output state_t              state
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASS - 1);

    state_t            state_next;
    logic [IDX_W-1:0]  wr_cnt;
    logic [IDX_W-1:0]  rd_cnt;
    logic [IDX_W-1:0]  best_idx;
    logic [DATA_W-1:0] best_val;
    logic [DATA_W-1:0] rd_data;
    logic              xfer;
    logic              cand_gt;
    logic [IDX_W-1:0]  scan_idx;
    logic [DATA_W-1:0] scan_val;

    assign xfer = bus.score_valid && bus.score_ready;

    score_bank #(
        .DATA_W  (DATA_W),
        .N_CLASS (N_CLASS)
    ) u_bank (
        .clk     (clk),
        .we      (xfer),
        .wr_addr (wr_cnt),
        .wr_data (bus.score_in),
        .rd_addr (rd_cnt),
        .rd_data (rd_data)
    );

    // Strictly-greater replace keeps the earliest index on ties.
    assign cand_gt  = rd_data > best_val;
    assign scan_val = cand_gt ? rd_data : best_val;
    assign scan_idx = cand_gt ? rd_cnt : best_idx;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (xfer && wr_cnt == LAST)  state_next = SCAN;
            SCAN:    if (rd_cnt == LAST)          state_next = DONE;
            DONE:    if (bus.result_ready)        state_next = COLLECT;
            default:                              state_next = COLLECT;
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        bus.score_ready  = (state == COLLECT);
        bus.result_valid = (state == DONE);
        busy             = !((state == COLLECT) && (wr_cnt == '0));
    end

    // Counters, running best and the registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt         <= '0;
            rd_cnt         <= '0;
            best_idx       <= '0;
            best_val       <= '0;
            bus.max_number <= '0;
            bus.max_value  <= '0;
        end else begin
            if (xfer) begin
                wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + IDX_W'(1);
            end
            case (state)
                COLLECT: begin
                    // Holding these at zero makes SCAN start from a clean best.
                    best_idx <= '0;
                    best_val <= '0;
                    rd_cnt   <= '0;
                end
                SCAN: begin
                    best_idx <= scan_idx;
                    best_val <= scan_val;
                    if (rd_cnt == LAST) begin
                        rd_cnt         <= '0;
                        bus.max_number <= scan_idx;
                        bus.max_value  <= scan_val;
                    end else begin
                        rd_cnt <= rd_cnt + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_sequencer.sv
module tb_argmax_sequencer;
    import argmax_sequencer_pkg::*;

    localparam int DATA_W  = 25;
    localparam int N_CLASS = 10;
    localparam int W       = IDX_W + DATA_W;
    localparam int WAIT_MAX = 300;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   busy;
    state_t dbg_state;

    argmax_sequencer_if #(.DATA_W(DATA_W)) bus ();

    argmax_sequencer #(
        .DATA_W  (DATA_W),
        .N_CLASS (N_CLASS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           n_total = 0;
    int           n_pass  = 0;
    logic [DATA_W-1:0] frame [N_CLASS];
    int           rr_mode = 1;   // 0 random, 1 hold high, 2 hold low
    bit           mon_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
    endtask

    // Reference: the largest value in the frame, and the first index holding it.
    function automatic logic [W-1:0] ref_result();
        logic [DATA_W-1:0] m;
        logic [IDX_W-1:0]  idx;
        m = '0;
        foreach (frame[i]) if (frame[i] > m) m = frame[i];
        idx = '0;
        for (int i = N_CLASS - 1; i >= 0; i--) if (frame[i] == m) idx = IDX_W'(i);
        return {idx, m};
    endfunction

    // ---------------- driver tasks ----------------
    initial begin
        bus.result_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                1:       bus.result_ready = 1'b1;
                2:       bus.result_ready = 1'b0;
                default: bus.result_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic load_frame(input int v[N_CLASS]);
        for (int i = 0; i < N_CLASS; i++) frame[i] = DATA_W'(v[i]);
    endtask

    // Sends the first n scores of frame[]; pushes the expected result when a
    // complete frame is sent and expect_res is set.
    task automatic send_scores(input int n, input bit expect_res, input int max_gap);
        int w;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(negedge clk);
                bus.score_valid = 1'b0;
                bus.score_in    = DATA_W'($urandom);
            end
            @(negedge clk);
            bus.score_in    = frame[i];
            bus.score_valid = 1'b1;
            w = 0;
            while (!bus.score_ready && w < WAIT_MAX) begin
                @(negedge clk);
                w++;
            end
            if (w >= WAIT_MAX) begin
                fail_now("score_ready_wait");
                bus.score_valid = 1'b0;
                return;
            end
            // Transfer happens on the coming edge, which ends cycle cyc.
            if (i == N_CLASS - 1 && expect_res) begin
                exp_q.push_back(ref_result());
                lat_q.push_back(cyc + N_CLASS + 1);
            end
        end
        @(negedge clk);
        bus.score_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < WAIT_MAX) begin
            @(negedge clk);
            w++;
        end
        if (w >= WAIT_MAX) begin
            fail_now("result_drain");
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    bit prev_rv = 1'b0;
    bit prev_hs = 1'b0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (prev_hs) check("valid_drop_after_handshake", 64'(bus.result_valid), 64'd0);
            if (bus.result_valid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_result: got idx %0d val 0x%0h expected no result (cycle %0d)",
                             bus.max_number, bus.max_value, cyc);
                end else begin
                    if (!prev_rv) check("result_latency", 64'(cyc), 64'(lat_q[0]));
                    check("result", 64'({bus.max_number, bus.max_value}), 64'(exp_q[0]));
                    check("score_ready_in_done", 64'(bus.score_ready), 64'd0);
                    if (bus.result_ready) begin
                        void'(exp_q.pop_front());
                        void'(lat_q.pop_front());
                    end
                end
            end
            prev_hs = bus.result_valid && bus.result_ready;
            prev_rv = bus.result_valid;
        end else begin
            prev_hs = 1'b0;
            prev_rv = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.score_in    = '0;
        bus.score_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_score_ready",  64'(bus.score_ready),  64'd1);
        check("rst_result_valid", 64'(bus.result_valid), 64'd0);
        check("rst_max_number",   64'(bus.max_number),   64'd0);
        check("rst_max_value",    64'(bus.max_value),    64'd0);
        check("rst_busy",         64'(busy),             64'd0);
        check("rst_state",        64'(dbg_state),        64'(COLLECT));
        mon_en = 1'b1;

        // Basic frame, consumer always ready: one-cycle result at T+11
        rr_mode = 1;
        load_frame('{3, 9, 1, 0, 0, 0, 0, 0, 0, 2});
        send_scores(N_CLASS, 1'b1, 0);
        @(negedge clk);
        check("busy_in_scan", 64'(busy), 64'd1);
        wait_drain();

        // All zeros
        load_frame('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        send_scores(N_CLASS, 1'b1, 0);
        wait_drain();

        // Tie resolves to lowest index
        load_frame('{5, 7, 7, 0, 0, 0, 0, 0, 7, 0});
        send_scores(N_CLASS, 1'b1, 0);
        wait_drain();

        // Full-scale value at the last index
        load_frame('{1, 1, 1, 1, 1, 1, 1, 1, 1, -1});
        send_scores(N_CLASS, 1'b1, 0);
        wait_drain();

        // Consumer stalls: result held, inputs ignored, next frame waits
        rr_mode = 2;
        load_frame('{4, 2, 11, 11, 0, 6, 1, 0, 3, 5});
        send_scores(N_CLASS, 1'b1, 0);
        fork
            begin
                repeat (N_CLASS + 1 + 20) @(posedge clk);
                rr_mode = 1;
            end
            begin
                load_frame('{2, 0, 0, 30, 0, 0, 0, 0, 0, 1});
                send_scores(N_CLASS, 1'b1, 0);
            end
        join
        wait_drain();

        // Reset after 4 scores: partial frame discarded
        load_frame('{9, 9, 9, 9, 9, 9, 9, 9, 9, 9});
        send_scores(4, 1'b0, 0);
        @(negedge clk);
        check("busy_partial_frame", 64'(busy), 64'd1);
        pulse_reset();
        @(negedge clk);
        check("busy_after_abort", 64'(busy), 64'd0);
        load_frame('{0, 0, 0, 0, 0, 0, 8, 0, 0, 0});
        send_scores(N_CLASS, 1'b1, 0);
        wait_drain();

        // Reset mid-scan: no result, ready again next cycle
        load_frame('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
        send_scores(N_CLASS, 1'b0, 0);
        repeat (2) @(posedge clk);
        pulse_reset();
        @(negedge clk);
        check("midscan_score_ready", 64'(bus.score_ready),  64'd1);
        check("midscan_result_valid", 64'(bus.result_valid), 64'd0);
        check("midscan_state",       64'(dbg_state),        64'(COLLECT));
        check("midscan_max_value",   64'(bus.max_value),    64'd0);
        repeat (N_CLASS + 4) @(negedge clk);
        check("midscan_no_result", 64'(bus.result_valid), 64'd0);

        // Randomized frames with random gaps and random consumer stalls
        rr_mode = 0;
        for (int f = 0; f < 24; f++) begin
            int kind;
            logic [DATA_W-1:0] same;
            kind = $urandom_range(0, 2);
            same = DATA_W'($urandom);
            for (int i = 0; i < N_CLASS; i++) begin
                case (kind)
                    0:       frame[i] = DATA_W'($urandom_range(0, 3));
                    1:       frame[i] = DATA_W'($urandom);
                    default: frame[i] = same;
                endcase
            end
            send_scores(N_CLASS, 1'b1, 2);
        end
        wait_drain();
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
